// File: rtl/axis_adc_burst.sv
// Burst / continuous multi-lane SPI ADC capture feeding an AXI4-Stream master
// through a small first-word-fall-through FIFO.
module axis_adc_burst #(
    parameter int NUM_SDI     = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int SCK_DIV     = 1,
    parameter int CONV_CYCLES = 4,
    parameter int BURST_WIDTH = 16,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   trigger,
    input  logic [BURST_WIDTH-1:0] burst_len,
    input  logic                   stop,
    output logic                   spi_csn,
    output logic                   spi_sck,
    input  logic [NUM_SDI-1:0]     spi_sdi,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   busy,
    output logic                   overflow
);

    localparam int BEATS = DATA_WIDTH / NUM_SDI;
    localparam int BW    = $clog2(BEATS) + 1;
    localparam int CW    = 16;
    localparam int AW    = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_SHIFT, S_PUSH} state_t;

    state_t                 r_state, w_next;
    logic [CW-1:0]          r_cnt;
    logic [BW-1:0]          r_beat;
    logic [BURST_WIDTH-1:0] r_remaining;
    logic                   r_cont, r_stop, r_busy, r_csn, r_sck, r_overflow;
    logic [DATA_WIDTH-1:0]  r_shift;

    logic [DATA_WIDTH:0]    r_mem [FIFO_DEPTH];
    logic [AW:0]            r_wr, r_rd;

    logic w_accept, w_conv_done, w_half_done, w_last_beat, w_last;
    logic w_push, w_pop, w_empty, w_full, w_push_ok;
    logic [DATA_WIDTH:0] w_head;

    assign w_accept    = (r_state == S_IDLE) && !r_busy && trigger;
    assign w_conv_done = (r_cnt == CW'(CONV_CYCLES - 1));
    assign w_half_done = (r_cnt == CW'(SCK_DIV - 1));
    assign w_last_beat = (r_beat == BW'(BEATS - 1));
    assign w_last      = r_cont ? r_stop : (r_remaining == BURST_WIDTH'(1));

    assign w_empty   = (r_wr == r_rd);
    assign w_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_pop     = !w_empty && m_axis_tready;
    assign w_push    = (r_state == S_PUSH);
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_head    = r_mem[r_rd[AW-1:0]];

    assign spi_csn       = r_csn;
    assign spi_sck       = r_sck;
    assign busy          = r_busy;
    assign overflow      = r_overflow;
    assign m_axis_tvalid = !w_empty;
    assign m_axis_tdata  = w_empty ? '0 : w_head[DATA_WIDTH-1:0];
    assign m_axis_tlast  = !w_empty && w_head[DATA_WIDTH];

    // State register
    always_ff @(posedge aclk) begin
        if (areset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode; IDLE spends one cycle with busy set before CONV
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (r_busy) w_next = S_CONV;
            S_CONV:  if (w_conv_done) w_next = S_SHIFT;
            S_SHIFT: if (r_sck && w_half_done && w_last_beat) w_next = S_PUSH;
            S_PUSH:  w_next = w_last ? S_IDLE : S_CONV;
            default: w_next = S_IDLE;
        endcase
    end

    // Sequencer datapath: counters, SPI pins, shift register, burst bookkeeping
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_cnt       <= '0;
            r_beat      <= '0;
            r_remaining <= '0;
            r_cont      <= 1'b0;
            r_busy      <= 1'b0;
            r_csn       <= 1'b1;
            r_sck       <= 1'b0;
            r_shift     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_remaining <= burst_len;
                        r_cont      <= (burst_len == '0);
                        r_busy      <= 1'b1;
                        r_cnt       <= '0;
                    end
                end
                S_CONV: begin
                    if (w_conv_done) begin
                        r_cnt  <= '0;
                        r_beat <= '0;
                        r_csn  <= 1'b0;
                        r_sck  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_SHIFT: begin
                    if (w_half_done) begin
                        r_cnt <= '0;
                        if (!r_sck) begin
                            r_sck   <= 1'b1;
                            r_shift <= (r_shift << NUM_SDI) | DATA_WIDTH'(spi_sdi);
                        end else begin
                            r_sck <= 1'b0;
                            if (w_last_beat) r_csn  <= 1'b1;
                            else             r_beat <= r_beat + BW'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_PUSH: begin
                    r_cnt <= '0;
                    if (!r_cont && (r_remaining > BURST_WIDTH'(1)))
                        r_remaining <= r_remaining - BURST_WIDTH'(1);
                    if (w_last) r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Stop latch, only meaningful for a continuous burst
    always_ff @(posedge aclk) begin
        if (areset || w_accept)           r_stop <= 1'b0;
        else if (r_busy && r_cont && stop) r_stop <= 1'b1;
    end

    // FIFO pointers and sticky overflow flag
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok)           r_wr       <= r_wr + (AW+1)'(1);
            if (w_pop)               r_rd       <= r_rd + (AW+1)'(1);
            if (w_push && !w_push_ok) r_overflow <= 1'b1;
        end
    end

    // FIFO storage: {last, data}
    always_ff @(posedge aclk) begin
        if (w_push_ok) r_mem[r_wr[AW-1:0]] <= {w_last, r_shift};
    end

endmodule

// File: tb/tb_axis_adc_burst.sv
// Directed bench for axis_adc_burst with a behavioural multi-lane ADC.
module tb_axis_adc_burst;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        trigger = 1'b0;
    logic [15:0] burst_len = '0;
    logic        stop = 1'b0;
    logic        spi_csn, spi_sck;
    logic [1:0]  spi_sdi = '0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tlast, busy, overflow;
    logic        m_axis_tready = 1'b0;

    int checks = 0;
    int errors = 0;

    axis_adc_burst #(
        .NUM_SDI(2), .DATA_WIDTH(32), .SCK_DIV(1),
        .CONV_CYCLES(4), .BURST_WIDTH(16), .FIFO_DEPTH(4)
    ) dut (
        .aclk(aclk), .areset(areset), .trigger(trigger), .burst_len(burst_len),
        .stop(stop), .spi_csn(spi_csn), .spi_sck(spi_sck), .spi_sdi(spi_sdi),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .busy(busy), .overflow(overflow)
    );

    always #5 aclk = ~aclk;

    // ADC model: loads a word on csn fall, shifts 2 bits after each SCK rise
    logic [31:0] adc_q[$];
    logic [31:0] adc_sh = '0;
    always @(negedge spi_csn or posedge spi_sck) begin
        #1;
        if (spi_sck === 1'b1) begin
            adc_sh = adc_sh << 2;
        end else begin
            if (adc_q.size() > 0) adc_sh = adc_q.pop_front();
            else                  adc_sh = '0;
        end
        spi_sdi = adc_sh[31:30];
    end

    // Monitor: accepted beats and pin activity counters
    logic [31:0] beat_data [256];
    logic        beat_last [256];
    int beat_cnt = 0, csn_low = 0, sck_rises = 0, csn_falls = 0, busy_cyc = 0;
    logic prev_sck = 1'b0, prev_csn = 1'b1;
    always @(negedge aclk) begin
        if (areset === 1'b0 && m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
            beat_data[beat_cnt[7:0]] <= m_axis_tdata;
            beat_last[beat_cnt[7:0]] <= m_axis_tlast;
            beat_cnt <= beat_cnt + 1;
        end
        if (spi_csn === 1'b0) csn_low <= csn_low + 1;
        if (busy === 1'b1) busy_cyc <= busy_cyc + 1;
        if (prev_sck === 1'b0 && spi_sck === 1'b1) sck_rises <= sck_rises + 1;
        if (prev_csn === 1'b1 && spi_csn === 1'b0) csn_falls <= csn_falls + 1;
        prev_sck <= spi_sck;
        prev_csn <= spi_csn;
    end

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        checks++; if (spi_csn !== 1'b1) begin errors++; $display("FAIL rst_csn got %b want 1", spi_csn); end
        checks++; if (spi_sck !== 1'b0) begin errors++; $display("FAIL rst_sck got %b want 0", spi_sck); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b want 0", m_axis_tvalid); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got %b want 0", m_axis_tlast); end
        checks++; if (m_axis_tdata !== 32'd0) begin errors++; $display("FAIL rst_tdata got %h want 0", m_axis_tdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b want 0", overflow); end
    endtask

    task automatic test_single();
        int b0, c0, s0, y0;
        bit ok;
        adc_q.delete(); adc_q.push_back(32'd2342);
        m_axis_tready = 1'b1; burst_len = 16'd1;
        b0 = beat_cnt; c0 = csn_low; s0 = sck_rises; y0 = busy_cyc;
        trigger = 1'b1; @(negedge aclk); trigger = 1'b0;
        ok = 0;
        for (int i = 0; i < 200; i++) begin @(negedge aclk); if (busy === 1'b0) begin ok = 1; break; end end
        checks++; if (!ok) begin errors++; $display("FAIL single_busy_timeout busy still %b", busy); end
        repeat (5) @(negedge aclk);
        checks++; if (beat_cnt - b0 !== 1) begin errors++; $display("FAIL single_beats got %0d want 1", beat_cnt - b0); end
        checks++; if (beat_data[b0] !== 32'd2342) begin errors++; $display("FAIL single_data got %0d want 2342", beat_data[b0]); end
        checks++; if (beat_last[b0] !== 1'b1) begin errors++; $display("FAIL single_last got %b want 1", beat_last[b0]); end
        checks++; if (busy_cyc - y0 !== 38) begin errors++; $display("FAIL single_busy_len got %0d want 38", busy_cyc - y0); end
        checks++; if (csn_low - c0 !== 32) begin errors++; $display("FAIL single_csn_low got %0d want 32", csn_low - c0); end
        checks++; if (sck_rises - s0 !== 16) begin errors++; $display("FAIL single_sck got %0d want 16", sck_rises - s0); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL single_overflow got %b want 0", overflow); end
    endtask

    task automatic test_finite_burst();
        logic [31:0] exp_w [3];
        int b0;
        bit ok;
        exp_w[0] = 32'h00000001; exp_w[1] = 32'h80000000; exp_w[2] = 32'hDEADBEEF;
        adc_q.delete();
        for (int k = 0; k < 3; k++) adc_q.push_back(exp_w[k]);
        m_axis_tready = 1'b1; burst_len = 16'd3;
        b0 = beat_cnt;
        trigger = 1'b1; @(negedge aclk); trigger = 1'b0;
        ok = 0;
        for (int i = 0; i < 400; i++) begin @(negedge aclk); if (busy === 1'b0) begin ok = 1; break; end end
        checks++; if (!ok) begin errors++; $display("FAIL burst_busy_timeout busy still %b", busy); end
        repeat (5) @(negedge aclk);
        checks++; if (beat_cnt - b0 !== 3) begin errors++; $display("FAIL burst_beats got %0d want 3", beat_cnt - b0); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (beat_data[b0+k] !== exp_w[k] || beat_last[b0+k] !== (k == 2)) begin
                errors++;
                $display("FAIL burst_beat%0d got %h/%b want %h/%b", k, beat_data[b0+k], beat_last[b0+k], exp_w[k], (k == 2));
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_busy_after got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        int b0;
        bit ok;
        adc_q.delete();
        for (int k = 1; k <= 6; k++) adc_q.push_back(32'(k));
        m_axis_tready = 1'b0; burst_len = 16'd6;
        b0 = beat_cnt;
        trigger = 1'b1; @(negedge aclk); trigger = 1'b0;
        ok = 0;
        for (int i = 0; i < 600; i++) begin @(negedge aclk); if (busy === 1'b0) begin ok = 1; break; end end
        checks++; if (!ok) begin errors++; $display("FAIL bp_busy_timeout busy still %b", busy); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow got %b want 1", overflow); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd1 || m_axis_tlast !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall%0d got v%b d%h l%b want v1 d00000001 l0", k, m_axis_tvalid, m_axis_tdata, m_axis_tlast);
            end
            @(negedge aclk);
        end
        m_axis_tready = 1'b1;
        repeat (8) @(negedge aclk);
        checks++; if (beat_cnt - b0 !== 4) begin errors++; $display("FAIL bp_beats got %0d want 4", beat_cnt - b0); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (beat_data[b0+k] !== 32'(k + 1) || beat_last[b0+k] !== 1'b0) begin
                errors++;
                $display("FAIL bp_beat%0d got %h/%b want %h/0", k, beat_data[b0+k], beat_last[b0+k], k + 1);
            end
        end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b want 0", m_axis_tvalid); end
    endtask

    task automatic test_trigger_reject();
        int b0, f0, n;
        bit ok;
        logic prev;
        adc_q.delete(); adc_q.push_back(32'h11112222); adc_q.push_back(32'h33334444);
        m_axis_tready = 1'b1; burst_len = 16'd2;
        b0 = beat_cnt; f0 = csn_falls;
        trigger = 1'b1; @(negedge aclk); trigger = 1'b0;
        ok = 0;
        for (int i = 0; i < 100; i++) begin @(negedge aclk); if (spi_csn === 1'b0) begin ok = 1; break; end end
        checks++; if (!ok) begin errors++; $display("FAIL rej_shift_timeout csn %b", spi_csn); end
        repeat (3) @(negedge aclk);
        trigger = 1'b1; @(negedge aclk); trigger = 1'b0;
        // walk csn edges to the PUSH of the second conversion
        ok = 0; n = 0; prev = spi_csn;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            if (spi_csn !== prev) begin n++; prev = spi_csn; if (n == 3) begin ok = 1; break; end end
        end
        checks++; if (!ok) begin errors++; $display("FAIL rej_push_timeout edges %0d want 3", n); end
        trigger = 1'b1; @(negedge aclk); trigger = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rej_busy_fall got %b want 0", busy); end
        repeat (60) @(negedge aclk);
        checks++; if (beat_cnt - b0 !== 2) begin errors++; $display("FAIL rej_beats got %0d want 2", beat_cnt - b0); end
        checks++;
        if (beat_data[b0] !== 32'h11112222 || beat_data[b0+1] !== 32'h33334444 || beat_last[b0] !== 1'b0 || beat_last[b0+1] !== 1'b1) begin
            errors++;
            $display("FAIL rej_data got %h/%b %h/%b want 11112222/0 33334444/1", beat_data[b0], beat_last[b0], beat_data[b0+1], beat_last[b0+1]);
        end
        checks++; if (csn_falls - f0 !== 2) begin errors++; $display("FAIL rej_csn_falls got %0d want 2", csn_falls - f0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rej_busy_idle got %b want 0", busy); end
    endtask

    task automatic test_continuous();
        int b0, f0, n;
        bit ok;
        logic prev;
        adc_q.delete();
        adc_q.push_back(32'hA5A5A5A5); adc_q.push_back(32'h5A5A5A5A); adc_q.push_back(32'h12345678);
        m_axis_tready = 1'b1; burst_len = 16'd0;
        b0 = beat_cnt; f0 = csn_falls;
        trigger = 1'b1; @(negedge aclk); trigger = 1'b0;
        ok = 0; n = 0; prev = spi_csn;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            if (spi_csn !== prev) begin n++; prev = spi_csn; if (n == 3) begin ok = 1; break; end end
        end
        checks++; if (!ok) begin errors++; $display("FAIL cont_shift2_timeout edges %0d want 3", n); end
        repeat (5) @(negedge aclk);
        stop = 1'b1; @(negedge aclk); stop = 1'b0;
        ok = 0;
        for (int i = 0; i < 200; i++) begin @(negedge aclk); if (busy === 1'b0) begin ok = 1; break; end end
        checks++; if (!ok) begin errors++; $display("FAIL cont_busy_timeout busy still %b", busy); end
        repeat (60) @(negedge aclk);
        checks++; if (beat_cnt - b0 !== 2) begin errors++; $display("FAIL cont_beats got %0d want 2", beat_cnt - b0); end
        checks++;
        if (beat_data[b0] !== 32'hA5A5A5A5 || beat_last[b0] !== 1'b0) begin
            errors++; $display("FAIL cont_beat0 got %h/%b want a5a5a5a5/0", beat_data[b0], beat_last[b0]);
        end
        checks++;
        if (beat_data[b0+1] !== 32'h5A5A5A5A || beat_last[b0+1] !== 1'b1) begin
            errors++; $display("FAIL cont_beat1 got %h/%b want 5a5a5a5a/1", beat_data[b0+1], beat_last[b0+1]);
        end
        checks++; if (csn_falls - f0 !== 2) begin errors++; $display("FAIL cont_csn_falls got %0d want 2", csn_falls - f0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_idle got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int b0, n;
        bit ok;
        logic prev;
        adc_q.delete();
        adc_q.push_back(32'd11); adc_q.push_back(32'd22); adc_q.push_back(32'd33);
        m_axis_tready = 1'b0; burst_len = 16'd3;
        trigger = 1'b1; @(negedge aclk); trigger = 1'b0;
        ok = 0; n = 0; prev = spi_csn;
        for (int i = 0; i < 300; i++) begin
            @(negedge aclk);
            if (spi_csn !== prev) begin n++; prev = spi_csn; if (n == 5) begin ok = 1; break; end end
        end
        checks++; if (!ok) begin errors++; $display("FAIL rmid_shift3_timeout edges %0d want 5", n); end
        repeat (5) @(negedge aclk);
        checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL rmid_prefill got %b want 1", m_axis_tvalid); end
        areset = 1'b1; @(negedge aclk); areset = 1'b0;
        checks++;
        if (spi_csn !== 1'b1 || spi_sck !== 1'b0 || m_axis_tvalid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL rmid_state got csn%b sck%b v%b busy%b ovf%b want 1 0 0 0 0", spi_csn, spi_sck, m_axis_tvalid, busy, overflow);
        end
        adc_q.delete(); adc_q.push_back(32'h0BADF00D);
        m_axis_tready = 1'b1; burst_len = 16'd1;
        b0 = beat_cnt;
        @(negedge aclk);
        trigger = 1'b1; @(negedge aclk); trigger = 1'b0;
        ok = 0;
        for (int i = 0; i < 200; i++) begin @(negedge aclk); if (busy === 1'b0) begin ok = 1; break; end end
        checks++; if (!ok) begin errors++; $display("FAIL rmid_busy_timeout busy still %b", busy); end
        repeat (5) @(negedge aclk);
        checks++; if (beat_cnt - b0 !== 1) begin errors++; $display("FAIL rmid_beats got %0d want 1", beat_cnt - b0); end
        checks++;
        if (beat_data[b0] !== 32'h0BADF00D || beat_last[b0] !== 1'b1) begin
            errors++; $display("FAIL rmid_word got %h/%b want 0badf00d/1", beat_data[b0], beat_last[b0]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_finite_burst();
        test_backpressure();
        test_trigger_reject();
        test_continuous();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/axis_adc_burst.md
Name: axis_adc_burst

Overview:
- Parametrised successor to the single-shot multi-lane SPI ADC capture block.
- Runs a burst of N conversions per trigger, or runs continuously until stopped, with a programmable SCK divider and conversion time.
- Captured words go into an internal FIFO that drives an AXI4-Stream master with tlast on the final word of a burst.
- Sits between the external ADC pins and the DMA stream path.

Parameters:
- NUM_SDI, 2, number of parallel SDI lanes; must divide DATA_WIDTH.
- DATA_WIDTH, 32, bits per conversion result.
- SCK_DIV, 1, SCK half-period in aclk cycles (>=1).
- CONV_CYCLES, 4, aclk cycles csn is held high per conversion (>=1).
- BURST_WIDTH, 16, width of the burst_len input.
- FIFO_DEPTH, 16, output FIFO words; power of two, >=2.

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous reset, active-high.
- trigger  in  1  start-of-burst pulse; sampled on aclk.
- burst_len  in  BURST_WIDTH  conversions per burst, latched on accepted trigger; 0 = continuous.
- stop  in  1  ends a continuous burst.
- spi_csn  out  1  ADC chip select / convert start, active-low.
- spi_sck  out  1  serial clock.
- spi_sdi  in  NUM_SDI  ADC data lanes.
- m_axis_tdata  out  DATA_WIDTH  sample word.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  last word of burst.
- busy  out  1  high from accepted trigger until the burst's final conversion has been pushed.
- overflow  out  1  sticky; a word was dropped because the FIFO was full.

Behaviour:
- Reset values: spi_csn=1, spi_sck=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, overflow=0.
- Reset also empties the FIFO and forces the FSM to IDLE, including when asserted mid-burst; the partial word is discarded.
- FSM states: IDLE, CONV, SHIFT, PUSH.
- IDLE: a trigger=1 is accepted only here.
  - Latches burst_len into the remaining counter and clears the stop latch.
  - Sets busy=1 and goes to CONV next cycle.
  - trigger in any other state, including the cycle busy falls, is ignored.
- CONV:
  - spi_csn=1 for CONV_CYCLES cycles, then spi_csn=0 and go to SHIFT.
- SHIFT:
  - Generates DATA_WIDTH/NUM_SDI SCK pulses, each SCK_DIV cycles low then SCK_DIV cycles high, starting low.
  - spi_sdi is sampled in the aclk cycle in which spi_sck is driven 0->1, i.e. the value present before the rising edge. The ADC updates its lanes after each rising edge and on the csn falling edge.
  - Beat k (k=0 first) fills bits [DATA_WIDTH-1-k*NUM_SDI -: NUM_SDI], with spi_sdi[NUM_SDI-1] as the MSB of the beat. MSB-first overall.
  - After the final rising edge, the cycle after the high phase ends: spi_sck=0, spi_csn=1, go to PUSH.
- PUSH (1 cycle):
  - Writes the word and a last flag into the FIFO. The last flag is set when remaining==1, or, in continuous mode, when the stop latch is set.
  - If the FIFO is full, the word is dropped and overflow is set. overflow clears only on areset.
  - Decrements remaining in finite mode.
  - If last: go to IDLE, and busy falls in the same cycle. Otherwise go to CONV.
- stop: latched while busy in continuous mode. The in-flight conversion completes and carries tlast. stop is ignored in finite mode.
- Per-conversion period: CONV_CYCLES + 2*SCK_DIV*(DATA_WIDTH/NUM_SDI) + 1 (PUSH) aclk cycles. With defaults this is 37.
- FIFO:
  - First-word-fall-through.
  - tvalid = not empty; a beat pops on tvalid & tready.
  - tdata/tlast must not change while tvalid=1 and tready=0.
  - A simultaneous push and pop while full is a push with no drop: the pop frees a slot first.
  - A word pushed into an empty FIFO is visible on tvalid the next cycle.
- A dropped last word means no tlast is emitted for that burst. This is intentional; overflow flags it.
- Counters wrap-free: remaining never decrements below 1 in finite mode.

Test Plan (NUM_SDI=2, DATA_WIDTH=32, SCK_DIV=1, CONV_CYCLES=4, FIFO_DEPTH=4; ADC model shifts a word per csn-low):
1. Single conversion:
   - Stimulus: burst_len=1, trigger pulse, ADC word 2342, tready=1.
   - Required: exactly one beat with tdata=2342 and tlast=1; busy high for 38 cycles; spi_csn low for 32 cycles with 16 SCK pulses; overflow=0.
2. Finite burst:
   - Stimulus: burst_len=3, ADC words 0x00000001, 0x80000000, 0xDEADBEEF, tready=1.
   - Required: three beats in that order; tlast only on 0xDEADBEEF; busy=0 afterwards.
3. Backpressure and overflow:
   - Stimulus: tready=0, burst_len=6, words 1..6.
   - Required: words 1..4 stored, words 5 and 6 dropped, overflow=1. Setting tready=1 then yields 1,2,3,4 with tlast never set, and tdata held stable while stalled.
4. Trigger rejection:
   - Stimulus: second trigger during SHIFT of a burst_len=2 run, and a further trigger in the cycle busy falls.
   - Required: exactly 2 beats total and no new csn activity.
5. Continuous mode:
   - Stimulus: burst_len=0, words 0xA5A5A5A5, 0x5A5A5A5A, 0x12345678, with stop pulsed during the second conversion's SHIFT.
   - Required: 2 beats, tlast on 0x5A5A5A5A, then IDLE; the third word is never converted.
6. Reset mid-operation:
   - Stimulus: areset=1 for 1 cycle during SHIFT with 2 words in the FIFO.
   - Required: the next cycle shows spi_csn=1, spi_sck=0, tvalid=0, busy=0, overflow=0. A following burst_len=1 trigger returns the correct word.
